// File: rtl/fsk_frame_tx.sv
// Framed FSK transmitter: sync + payload + mark gap, baseband bit plus counter-derived FSK tone.
// Optional Hamming(12,8) payload encoding is compiled in with FSK_TX_HAMMING_EN.
module fsk_frame_tx #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       CLK_PER_BIT = 100,
  parameter int unsigned       F0_HALF     = 10,
  parameter int unsigned       F1_HALF     = 5,
  parameter int unsigned       SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC        = 8'hA7,
  parameter int unsigned       GAP_BITS    = 2,
  parameter int unsigned       ERR_POS     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              err_inject,
  output logic              tx_bit,
  output logic              fsk_out,
  output logic              busy,
  output logic              frame_done
);

`ifdef FSK_TX_HAMMING_EN
  localparam int unsigned PAY_W = 12;
`else
  localparam int unsigned PAY_W = DATA_W;
`endif
  localparam int unsigned FRAME_W  = SYNC_W + PAY_W + GAP_BITS;
  localparam int unsigned BIT_W    = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_MAX0 = (SYNC_W > PAY_W) ? SYNC_W : PAY_W;
  localparam int unsigned IDX_MAX  = (IDX_MAX0 > GAP_BITS) ? IDX_MAX0 : GAP_BITS;
  localparam int unsigned IDX_W    = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int unsigned TONE_MAX = (F0_HALF > F1_HALF) ? F0_HALF : F1_HALF;
  localparam int unsigned TONE_W   = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;

`ifdef FSK_TX_HAMMING_EN
  if (DATA_W != 8) begin : g_bad_data_w
    $error("fsk_frame_tx: DATA_W must be 8 when Hamming encoding is enabled");
  end
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_GAP} state_t;

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt, last_idx;
  logic [FRAME_W-1:0] frame_sr, frame_nxt;
  logic [TONE_W-1:0]  tone_cnt, tone_nxt, half_m1;
  logic               fsk_nxt, tx_nxt, busy_nxt, ready_nxt, done_nxt;
  logic               bit_end;
  logic [PAY_W-1:0]   payload_c;

  // Hamming(12,8): returned bit p-1 holds codeword position p, so c12 is the MSB.
  function automatic logic [PAY_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef FSK_TX_HAMMING_EN
    logic [12:1] c;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[12] = d[7];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
    return c;
`else
    return d;
`endif
  endfunction

  assign payload_c = encode(in_data) ^ (PAY_W'(err_inject) << ERR_POS);
  assign bit_end   = (state != ST_IDLE) && (bit_cnt == BIT_W'(CLK_PER_BIT - 1));
  assign half_m1   = tx_bit ? TONE_W'(F1_HALF - 1) : TONE_W'(F0_HALF - 1);

  always_comb begin
    case (state)
      ST_SYNC:    last_idx = IDX_W'(SYNC_W - 1);
      ST_PAYLOAD: last_idx = IDX_W'(PAY_W - 1);
      ST_GAP:     last_idx = IDX_W'(GAP_BITS - 1);
      default:    last_idx = '0;
    endcase
  end

  // Next-state, bit sequencing and registered-output next values.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    frame_nxt   = frame_sr;
    done_nxt    = 1'b0;
    tone_nxt    = tone_cnt;
    fsk_nxt     = fsk_out;

    if (state == ST_IDLE) begin
      bit_cnt_nxt = '0;
      bit_idx_nxt = '0;
      if (in_valid && in_ready) begin
        frame_nxt = {SYNC, payload_c, {GAP_BITS{1'b1}}};
        state_nxt = ST_SYNC;
      end
    end else if (bit_end) begin
      bit_cnt_nxt = '0;
      frame_nxt   = {frame_sr[FRAME_W-2:0], 1'b1};
      if (bit_idx == last_idx) begin
        bit_idx_nxt = '0;
        case (state)
          ST_SYNC:    state_nxt = ST_PAYLOAD;
          ST_PAYLOAD: state_nxt = ST_GAP;
          default: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        endcase
      end else begin
        bit_idx_nxt = bit_idx + IDX_W'(1);
      end
    end else begin
      bit_cnt_nxt = bit_cnt + BIT_W'(1);
    end

    busy_nxt  = (state_nxt != ST_IDLE);
    ready_nxt = (state_nxt == ST_IDLE);
    tx_nxt    = (state_nxt == ST_IDLE) ? 1'b1 : frame_nxt[FRAME_W-1];

    // Tone is silent in IDLE and phase-continuous across bit boundaries.
    if (state == ST_IDLE || state_nxt == ST_IDLE) begin
      tone_nxt = '0;
      fsk_nxt  = 1'b0;
    end else if (bit_end) begin
      tone_nxt = '0;
    end else if (tone_cnt == half_m1) begin
      tone_nxt = '0;
      fsk_nxt  = ~fsk_out;
    end else begin
      tone_nxt = tone_cnt + TONE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      frame_sr   <= '0;
      tone_cnt   <= '0;
      fsk_out    <= 1'b0;
      tx_bit     <= 1'b1;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      frame_sr   <= frame_nxt;
      tone_cnt   <= tone_nxt;
      fsk_out    <= fsk_nxt;
      tx_bit     <= tx_nxt;
      busy       <= busy_nxt;
      in_ready   <= ready_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fsk_frame_tx.sv
// Directed self-checking bench for fsk_frame_tx (raw or Hamming payload per FSK_TX_HAMMING_EN).
module tb_fsk_frame_tx;

  localparam int unsigned CPB = 8;
  localparam int unsigned F0  = 2;
  localparam int unsigned F1  = 1;
`ifdef FSK_TX_HAMMING_EN
  localparam int unsigned PW = 12;
  localparam logic [PW-1:0] P_FF     = 12'hF77;
  localparam logic [PW-1:0] P_00     = 12'h000;
  localparam logic [PW-1:0] P_FF_ERR = 12'hFF7;
  localparam logic [PW-1:0] P_5A     = 12'h550;
`else
  localparam int unsigned PW = 8;
  localparam logic [PW-1:0] P_FF     = 8'hFF;
  localparam logic [PW-1:0] P_00     = 8'h00;
  localparam logic [PW-1:0] P_FF_ERR = 8'h7F;
  localparam logic [PW-1:0] P_5A     = 8'h5A;
`endif
  localparam int unsigned FW   = 8 + PW + 2;
  localparam int unsigned NCYC = FW * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       err_inject;
  logic       tx_bit;
  logic       fsk_out;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  fsk_frame_tx #(
    .DATA_W(8), .CLK_PER_BIT(CPB), .F0_HALF(F0), .F1_HALF(F1),
    .SYNC_W(8), .SYNC(8'hA7), .GAP_BITS(2), .ERR_POS(7)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .err_inject(err_inject), .tx_bit(tx_bit),
    .fsk_out(fsk_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic handshake(input logic [7:0] w, input logic e);
    @(negedge clk);
    check("ready_before_hs", 32'(in_ready), 32'd1);
    in_data    = w;
    err_inject = e;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_data    = ~w;
    err_inject = ~e;
  endtask

  // Called just after the handshake edge; returns at the first IDLE cycle.
  task automatic check_frame(input logic [PW-1:0] pay, input string name);
    logic [FW-1:0] fr;
    logic          lvl, b, e;
    int            k, h;
    fr  = {8'hA7, pay, 2'b11};
    lvl = 1'b0;
    for (int c = 0; c < int'(NCYC); c++) begin
      b = fr[FW-1-(c/CPB)];
      k = c % CPB;
      h = b ? F1 : F0;
      e = lvl ^ (((k / h) % 2) == 1);
      @(negedge clk);
      check($sformatf("%s tx c%0d", name, c), 32'(tx_bit), 32'(b));
      check($sformatf("%s fsk c%0d", name, c), 32'(fsk_out), 32'(e));
      check($sformatf("%s busy/ready/done c%0d", name, c),
            32'({busy, in_ready, frame_done}), 32'(3'b100));
      if (k == int'(CPB) - 1) lvl = lvl ^ ((((CPB - 1) / h) % 2) == 1);
    end
    @(negedge clk);
    check($sformatf("%s end busy/ready/done/tx/fsk", name),
          32'({busy, in_ready, frame_done, tx_bit, fsk_out}), 32'(5'b01110));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_done, seen_busy;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    err_inject = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst tx_bit", 32'(tx_bit), 32'd1);
    check("rst fsk_out", 32'(fsk_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;

    handshake(8'h5A, 1'b0);
    check_frame(P_5A, "f5a");
    @(negedge clk);
    check("f5a done one cycle", 32'(frame_done), 32'd0);

    handshake(8'hFF, 1'b0);
    check_frame(P_FF, "fff");
    handshake(8'h00, 1'b0);
    check_frame(P_00, "f00");
    handshake(8'hFF, 1'b1);
    check_frame(P_FF_ERR, "fff_err");

    // Back-to-back with in_valid held high; the second word waits in in_data.
    @(negedge clk);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h5A;
    check_frame(P_FF, "b2b_a");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_frame(P_5A, "b2b_b");

    // Reset during payload bit 3 (frame cycle 88).
    handshake(8'h5A, 1'b0);
    repeat (89) @(negedge clk);
    check("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready/tx/fsk/busy/done",
          32'({in_ready, tx_bit, fsk_out, busy, frame_done}), 32'(5'b11000));
    rst = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_done = seen_done | frame_done;
      seen_busy = seen_busy | busy;
    end
    check("midrst no frame_done", 32'(seen_done), 32'd0);
    check("midrst stays idle", 32'(seen_busy), 32'd0);
    handshake(8'h5A, 1'b0);
    check_frame(P_5A, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
